// File: rtl/bp_pkg.sv
// Shared types, counter encodings and saturating-counter helpers for the
// branch prediction unit and its target buffer.
package bp_pkg;

    // Stored tag field is wide enough for any legal PC_W; narrower tags are
    // zero-extended on both write and compare.
    localparam int TAG_MAX_W = 30;

    // 2-bit saturating counter states
    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer storage: flop array with asynchronous
// clear, one combinational read port and one synchronous read-modify-write
// training port. The training port decides allocate / update / decay itself
// from the entry it is about to overwrite.
module btb_table
    import bp_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output btb_entry_t       rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic             wr_force_strong,
    input  logic [31:0]      wr_target
);

    localparam btb_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: 32'd0, ctr: CTR_WNT};

    btb_entry_t             w_entries [DEPTH];
    btb_entry_t             w_cur;
    btb_entry_t             w_next;
    logic                   w_hit;
    logic [TAG_MAX_W-1:0]   w_wr_tag_ext;

    assign rd_entry     = w_entries[rd_idx];
    assign w_cur        = w_entries[wr_idx];
    assign w_wr_tag_ext = TAG_MAX_W'(wr_tag);
    assign w_hit        = w_cur.valid && (w_cur.tag == w_wr_tag_ext);

    // New contents for the trained entry: allocate on a taken miss, refresh
    // and strengthen on a taken hit, weaken on a not-taken hit.
    always_comb begin
        w_next = w_cur;
        if (wr_taken) begin
            if (!w_hit) begin
                w_next.valid  = 1'b1;
                w_next.tag    = w_wr_tag_ext;
                w_next.target = wr_target;
                w_next.ctr    = CTR_WT;
            end else begin
                w_next.target = wr_target;
                w_next.ctr    = wr_force_strong ? CTR_ST : sat_inc(w_cur.ctr);
            end
        end else if (w_hit) begin
            w_next.ctr = sat_dec(w_cur.ctr);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            btb_entry_t r_entry;

            // One entry register; cleared immediately by reset, written only
            // when the training port targets this index.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= ENTRY_RESET;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    r_entry <= w_next;
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: BTB lookup for fetch, control-flow resolution and
// redirect for execute, registered table training and event statistics.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [31:0]     f_pred_pc,
    input  logic            e_valid,
    input  logic [PC_W-1:0] e_pc,
    input  logic [31:0]     e_imm,
    input  logic            e_branch,
    input  logic            e_jalr,
    input  logic            e_jump,
    input  logic [31:0]     e_alu_result,
    input  logic            e_halt,
    input  logic            e_pred_taken,
    input  logic [31:0]     e_pred_pc,
    output logic [31:0]     pc_imm,
    output logic [31:0]     pc_four,
    output logic            pc_sel,
    output logic [31:0]     br_pc,
    output logic            mispredict,
    output logic [31:0]     stat_br,
    output logic [31:0]     stat_mis
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;

    btb_entry_t         w_rd_entry;
    logic [IDX_W-1:0]   w_f_idx;
    logic [TAG_W-1:0]   w_f_tag;
    logic [31:0]        w_f_pc32;
    logic               w_f_hit;
    logic [31:0]        w_e_pc32;
    logic               w_cf;
    logic               w_taken;
    logic               w_train;
    logic               w_cf_mis;
    logic               w_stale_mis;
    logic [31:0]        r_stat_br;
    logic [31:0]        r_stat_mis;

    // Fetch-side lookup
    assign w_f_idx  = f_pc[IDX_W+1:2];
    assign w_f_tag  = f_pc[PC_W-1:IDX_W+2];
    assign w_f_pc32 = 32'(f_pc);
    assign w_f_hit  = w_rd_entry.valid
                   && (w_rd_entry.tag == TAG_MAX_W'(w_f_tag))
                   && (w_rd_entry.ctr >= CTR_WT);

    assign f_pred_taken = w_f_hit;
    assign f_pred_pc    = w_f_hit ? w_rd_entry.target : w_f_pc32 + 32'd4;

    // Execute-side resolution
    assign w_e_pc32 = 32'(e_pc);
    assign pc_four  = w_e_pc32 + 32'd4;
    assign pc_imm   = e_jalr ? e_alu_result : w_e_pc32 + e_imm;
    assign w_cf     = e_valid & (e_branch | e_jalr | e_jump);
    assign w_taken  = e_jump | e_jalr | (e_branch & e_alu_result[0]);
    assign w_train  = w_cf & ~e_halt;
    assign w_cf_mis = w_train & ((w_taken != e_pred_taken) | (w_taken & (e_pred_pc != pc_imm)));
    // A non-branch that fetch predicted taken (BTB alias) must fall through.
    assign w_stale_mis = e_valid & ~w_cf & ~e_halt & e_pred_taken;
    assign mispredict  = w_cf_mis | w_stale_mis;

    // Redirect selection: halt first, then mispredict recovery.
    always_comb begin
        pc_sel = 1'b0;
        br_pc  = 32'd0;
        if (e_halt) begin
            pc_sel = 1'b1;
            br_pc  = w_e_pc32;
        end else if (mispredict) begin
            pc_sel = 1'b1;
            br_pc  = w_taken ? pc_imm : pc_four;
        end
    end

    btb_table #(
        .DEPTH (BTB_DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_idx          (w_f_idx),
        .rd_entry        (w_rd_entry),
        .wr_en           (w_train),
        .wr_idx          (e_pc[IDX_W+1:2]),
        .wr_tag          (e_pc[PC_W-1:IDX_W+2]),
        .wr_taken        (w_taken),
        .wr_force_strong (e_jump | e_jalr),
        .wr_target       (pc_imm)
    );

    // Resolved control-flow and mispredict counters, free-running modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br  <= 32'd0;
            r_stat_mis <= 32'd0;
        end else begin
            if (w_train)    r_stat_br  <= r_stat_br + 32'd1;
            if (mispredict) r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign stat_br  = r_stat_br;
    assign stat_mis = r_stat_mis;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (PC_W=9, 16 entries).
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [8:0]  f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_pc;
    logic        e_valid;
    logic [8:0]  e_pc;
    logic [31:0] e_imm;
    logic        e_branch;
    logic        e_jalr;
    logic        e_jump;
    logic [31:0] e_alu_result;
    logic        e_halt;
    logic        e_pred_taken;
    logic [31:0] e_pred_pc;
    logic [31:0] pc_imm;
    logic [31:0] pc_four;
    logic        pc_sel;
    logic [31:0] br_pc;
    logic        mispredict;
    logic [31:0] stat_br;
    logic [31:0] stat_mis;

    int checks = 0;
    int errors = 0;

    branch_predict_unit #(.PC_W(9), .BTB_DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_pc         (f_pc),
        .f_pred_taken (f_pred_taken),
        .f_pred_pc    (f_pred_pc),
        .e_valid      (e_valid),
        .e_pc         (e_pc),
        .e_imm        (e_imm),
        .e_branch     (e_branch),
        .e_jalr       (e_jalr),
        .e_jump       (e_jump),
        .e_alu_result (e_alu_result),
        .e_halt       (e_halt),
        .e_pred_taken (e_pred_taken),
        .e_pred_pc    (e_pred_pc),
        .pc_imm       (pc_imm),
        .pc_four      (pc_four),
        .pc_sel       (pc_sel),
        .br_pc        (br_pc),
        .mispredict   (mispredict),
        .stat_br      (stat_br),
        .stat_mis     (stat_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ex_idle();
        e_valid = 0; e_pc = '0; e_imm = '0; e_branch = 0; e_jalr = 0; e_jump = 0;
        e_alu_result = '0; e_halt = 0; e_pred_taken = 0; e_pred_pc = '0;
    endtask

    task automatic ex_set(input logic [8:0] pc, input logic [31:0] imm, input logic br,
                          input logic jr, input logic jmp, input logic [31:0] alu,
                          input logic pt, input logic [31:0] ppc);
        e_valid = 1; e_pc = pc; e_imm = imm; e_branch = br; e_jalr = jr; e_jump = jmp;
        e_alu_result = alu; e_halt = 0; e_pred_taken = pt; e_pred_pc = ppc;
    endtask

    task automatic lookup(input string tag, input logic [8:0] pc, input logic exp_t, input logic [31:0] exp_pc);
        f_pc = pc;
        #1;
        chk({tag, "_taken"}, 32'(f_pred_taken), 32'(exp_t));
        chk({tag, "_pc"},    f_pred_pc, exp_pc);
    endtask

    task automatic ex_chk(input string tag, input logic exp_sel, input logic [31:0] exp_br, input logic exp_mis);
        #1;
        chk({tag, "_pc_sel"},     32'(pc_sel), 32'(exp_sel));
        chk({tag, "_br_pc"},      br_pc, exp_br);
        chk({tag, "_mispredict"}, 32'(mispredict), 32'(exp_mis));
        $display("step %s: pc_sel=%0b br_pc=%h mispredict=%0b", tag, pc_sel, br_pc, mispredict);
    endtask

    task automatic stat_chk(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mis);
        chk({tag, "_stat_br"},  stat_br, exp_br);
        chk({tag, "_stat_mis"}, stat_mis, exp_mis);
    endtask

    initial begin
        // Reset state
        rst_n = 0; f_pc = '0; ex_idle();
        #3;
        ex_chk("reset", 0, 32'h0, 0);
        stat_chk("reset", 0, 0);
        lookup("reset_lk", 9'h010, 0, 32'h14);
        @(negedge clk);
        rst_n = 1;
        tick();

        // First taken branch allocates; same-cycle lookup still sees old table
        lookup("pre_alloc", 9'h010, 0, 32'h14);
        ex_set(9'h010, 32'h20, 1, 0, 0, 32'h1, 0, 32'h0);
        ex_chk("br_alloc", 1, 32'h30, 1);
        chk("br_alloc_pc_imm", pc_imm, 32'h30);
        chk("br_alloc_pc_four", pc_four, 32'h14);
        tick();
        ex_idle();
        lookup("post_alloc", 9'h010, 1, 32'h30);
        stat_chk("post_alloc", 1, 1);

        // Correctly predicted taken: counter to 3, no redirect
        ex_set(9'h010, 32'h20, 1, 0, 0, 32'h1, 1, 32'h30);
        ex_chk("br_strong", 0, 32'h0, 0);
        tick();

        // Two not-taken resolutions, each mispredicted
        ex_set(9'h010, 32'h20, 1, 0, 0, 32'h0, 1, 32'h30);
        ex_chk("br_nt1", 1, 32'h14, 1);
        tick();
        ex_idle();
        lookup("after_nt1", 9'h010, 1, 32'h30);
        ex_set(9'h010, 32'h20, 1, 0, 0, 32'h0, 1, 32'h30);
        ex_chk("br_nt2", 1, 32'h14, 1);
        tick();
        ex_idle();
        lookup("after_nt2", 9'h010, 0, 32'h14);
        stat_chk("after_nt2", 4, 3);

        // Wrong predicted target on a taken branch also mispredicts
        ex_set(9'h010, 32'h20, 1, 0, 0, 32'h1, 1, 32'h34);
        ex_chk("br_bad_tgt", 1, 32'h30, 1);
        tick();
        ex_idle();
        lookup("after_bad_tgt", 9'h010, 1, 32'h30);
        stat_chk("after_bad_tgt", 5, 4);

        // JALR correctly predicted
        ex_set(9'h040, 32'h0, 0, 1, 0, 32'h100, 1, 32'h100);
        ex_chk("jalr", 0, 32'h0, 0);
        chk("jalr_pc_imm", pc_imm, 32'h100);
        tick();
        ex_idle();
        stat_chk("after_jalr", 6, 4);
        lookup("after_jalr", 9'h040, 1, 32'h100);

        // Aliasing: 0x004 and 0x044 share index 1
        ex_set(9'h004, 32'h10, 0, 0, 1, 32'h0, 0, 32'h0);
        ex_chk("jmp_004", 1, 32'h14, 1);
        tick();
        ex_idle();
        lookup("hit_004", 9'h004, 1, 32'h14);
        ex_set(9'h044, 32'h8, 0, 0, 1, 32'h0, 0, 32'h0);
        ex_chk("jmp_044", 1, 32'h4C, 1);
        tick();
        ex_idle();
        lookup("miss_004", 9'h004, 0, 32'h8);
        lookup("hit_044", 9'h044, 1, 32'h4C);
        stat_chk("after_alias", 8, 6);

        // Halt held over a taken branch: no training, no stats
        ex_set(9'h080, 32'h10, 1, 0, 0, 32'h1, 0, 32'h0);
        e_halt = 1;
        ex_chk("halt1", 1, 32'h80, 0);
        tick();
        ex_chk("halt2", 1, 32'h80, 0);
        tick();
        ex_idle();
        lookup("after_halt", 9'h080, 0, 32'h84);
        stat_chk("after_halt", 8, 6);

        // Halt with a bubble still redirects
        e_halt = 1; e_pc = 9'h0C0;
        ex_chk("halt_bubble", 1, 32'hC0, 0);
        ex_idle();

        // Bubble carrying a taken prediction is ignored
        e_pred_taken = 1; e_pred_pc = 32'h30;
        ex_chk("bubble_pred", 0, 32'h0, 0);

        // Stale alias: non-branch predicted taken falls through
        ex_set(9'h020, 32'h0, 0, 0, 0, 32'h0, 1, 32'h30);
        ex_chk("stale", 1, 32'h24, 1);
        tick();
        ex_idle();
        stat_chk("after_stale", 8, 7);

        // Asynchronous reset between edges clears table and stats at once
        lookup("pre_rst", 9'h040, 1, 32'h100);
        rst_n = 0;
        #1;
        chk("rst_async_taken", 32'(f_pred_taken), 32'd0);
        chk("rst_async_pc", f_pred_pc, 32'h44);
        stat_chk("rst_async", 0, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        lookup("post_rst_044", 9'h044, 0, 32'h48);
        stat_chk("post_rst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
